// File: rtl/psg_filter_pkg.sv
// Shared constants and types for the PSG filter coefficient loader.
// CPU register map, control bit positions, loader FSM states and coefficient word.
package psg_filter_pkg;
    localparam int COEF_W = 13;

    localparam logic [4:0] ADDR_CTRL = 5'd16;
    localparam logic [4:0] ADDR_STAT = 5'd17;

    localparam int COMMIT  = 0;
    localparam int ERR_CLR = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        LOAD      = 2'd2
    } state_e;

    typedef logic [COEF_W-1:0] coef_t;
endpackage

// File: rtl/psg_filter_coef_loader_seq.sv
// Free-running sample-phase counter with load-sync and capture decodes.
// Decodes are combinational from the registered count; no backpressure.
module psg_sample_seq #(
    parameter int TAPS    = 16,
    parameter int CNT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] cnt_o,
    output logic       sync_o,
    output logic       cap_o
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == 8'(CNT_MAX)) ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign sync_o = (cnt_q == 8'(TAPS - 1));
    assign cap_o  = (cnt_q == 8'd1);
endmodule

// File: rtl/psg_filter_coef_loader.sv
// CPU shadow of the FIR taps, streamed into the filter during the idle phase after commit.
// Read data 1 cycle; load waits up to CNT_MAX+1 clocks for sync, then TAPS writes.
module psg_filter_coef_loader
    import psg_filter_pkg::*;
#(
    parameter int TAPS    = 16,
    parameter int CNT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_addr,
    input  logic [12:0] cpu_din,
    output logic [12:0] cpu_dout,
    output logic [7:0]  cnt,
    output logic        f_wr,
    output logic [3:0]  f_adr,
    output logic [12:0] f_din,
    input  logic [14:0] f_o,
    output logic [14:0] smp_o,
    output logic        smp_valid,
    output logic        busy
);
    localparam int IW = $clog2(TAPS);

    logic        sync, cap;
    coef_t       shadow_q [TAPS];
    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        f_wr_q, f_wr_d;
    logic [3:0]  f_adr_q, f_adr_d, adr_inc;
    coef_t       f_din_q, f_din_d;
    coef_t       cpu_dout_q, cpu_dout_d;
    logic [14:0] smp_q;
    logic        smp_vld_q;

    logic is_tap, shadow_we, ctrl_we, commit, err_clr, err_set;

    psg_sample_seq #(.TAPS(TAPS), .CNT_MAX(CNT_MAX)) u_seq (
        .clk    (clk),
        .rst    (rst),
        .cnt_o  (cnt),
        .sync_o (sync),
        .cap_o  (cap)
    );

    assign is_tap    = (cpu_addr < 5'(TAPS));
    assign shadow_we = cpu_we && is_tap && !busy_q;
    assign ctrl_we   = cpu_we && (cpu_addr == ADDR_CTRL);
    assign commit    = ctrl_we && cpu_din[COMMIT];
    assign err_clr   = ctrl_we && cpu_din[ERR_CLR];
    // Any tap write or commit that arrives mid-load is lost; flag it to software.
    assign err_set   = busy_q && ((cpu_we && is_tap) || commit);
    assign adr_inc   = f_adr_q + 4'd1;

    always_comb begin
        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (err_set) err_d = 1'b1;
    end

    // Address 0 is issued on the sync edge so the writes occupy cnt = TAPS..2*TAPS-1.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        f_wr_d  = 1'b0;
        f_adr_d = f_adr_q;
        f_din_d = f_din_q;
        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = WAIT_SYNC;
                    busy_d  = 1'b1;
                end
            end
            WAIT_SYNC: begin
                if (sync) begin
                    state_d = LOAD;
                    f_wr_d  = 1'b1;
                    f_adr_d = 4'd0;
                    f_din_d = shadow_q[0];
                end
            end
            LOAD: begin
                if (f_adr_q == 4'(TAPS - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    f_wr_d  = 1'b1;
                    f_adr_d = adr_inc;
                    f_din_d = shadow_q[adr_inc[IW-1:0]];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_dout_d = '0;
        if (is_tap)                      cpu_dout_d = shadow_q[cpu_addr[IW-1:0]];
        else if (cpu_addr == ADDR_STAT)  cpu_dout_d = {11'd0, err_q, busy_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) shadow_q[i] <= '0;
        end else if (shadow_we) begin
            shadow_q[cpu_addr[IW-1:0]] <= cpu_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            f_wr_q     <= 1'b0;
            f_adr_q    <= '0;
            f_din_q    <= '0;
            cpu_dout_q <= '0;
            smp_q      <= '0;
            smp_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            f_wr_q     <= f_wr_d;
            f_adr_q    <= f_adr_d;
            f_din_q    <= f_din_d;
            cpu_dout_q <= cpu_dout_d;
            smp_vld_q  <= cap;
            if (cap) smp_q <= f_o;
        end
    end

    assign cpu_dout  = cpu_dout_q;
    assign f_wr      = f_wr_q;
    assign f_adr     = f_adr_q;
    assign f_din     = f_din_q;
    assign smp_o     = smp_q;
    assign smp_valid = smp_vld_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_psg_filter_coef_loader.sv
// Scoreboard bench: a timing-level reference model pushes expectations per edge,
// a negedge monitor pops and compares them against the DUT.
module tb_psg_filter_coef_loader;
    localparam int TAPS    = 16;
    localparam int CNT_MAX = 255;
    localparam int PERIOD  = CNT_MAX + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_we = 1'b0;
    logic [4:0]  cpu_addr = '0;
    logic [12:0] cpu_din = '0;
    logic [14:0] f_o = '0;
    logic [12:0] cpu_dout;
    logic [7:0]  cnt;
    logic        f_wr;
    logic [3:0]  f_adr;
    logic [12:0] f_din;
    logic [14:0] smp_o;
    logic        smp_valid;
    logic        busy;

    psg_filter_coef_loader #(.TAPS(TAPS), .CNT_MAX(CNT_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cnt       (cnt),
        .f_wr      (f_wr),
        .f_adr     (f_adr),
        .f_din     (f_din),
        .f_o       (f_o),
        .smp_o     (smp_o),
        .smp_valid (smp_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint      v;
        logic [3:0]  adr;
        logic [12:0] din;
        logic [7:0]  cnt;
    } wr_t;

    typedef struct {
        longint      v;
        logic [14:0] smp;
    } sm_t;

    wr_t         wr_q[$];
    sm_t         sm_q[$];
    logic [12:0] rd_q[$];

    logic [12:0] m_shadow [TAPS];
    logic        m_err = 1'b0;
    longint      load_end = -1;
    longint      load_start = -1;
    longint      edge_n = 0;
    int          mcnt = 0;
    logic        exp_busy = 1'b0;
    bit          started = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // One clock edge: the model consumes the inputs the DUT samples on the same edge.
    task automatic step();
        logic        busy_pre;
        logic [12:0] dout;
        @(posedge clk);
        edge_n++;
        busy_pre = (edge_n <= load_end);
        dout = '0;
        if (rst) begin
            for (int i = 0; i < TAPS; i++) m_shadow[i] = '0;
            m_err    = 1'b0;
            load_end = -1;
            mcnt     = 0;
            wr_q.delete();
            sm_q.delete();
        end else begin
            if (cpu_addr < TAPS)    dout = m_shadow[cpu_addr[3:0]];
            else if (cpu_addr == 17) dout = {11'd0, m_err, busy_pre};
            if (mcnt == 1) sm_q.push_back('{edge_n, f_o});
            if (cpu_we && cpu_addr < TAPS) begin
                if (busy_pre) m_err = 1'b1;
                else          m_shadow[cpu_addr[3:0]] = cpu_din;
            end
            if (cpu_we && cpu_addr == 16) begin
                if (cpu_din[1]) m_err = 1'b0;
                if (cpu_din[0]) begin
                    if (busy_pre) begin
                        m_err = 1'b1;
                    end else begin
                        int d;
                        d = (TAPS - 1 - mcnt + PERIOD) % PERIOD;
                        if (d == 0) d = PERIOD;
                        load_start = edge_n + d;
                        for (int k = 0; k < TAPS; k++)
                            wr_q.push_back('{load_start + k, 4'(k), m_shadow[k], 8'(TAPS + k)});
                        load_end = load_start + TAPS;
                    end
                end
            end
            mcnt = (mcnt == CNT_MAX) ? 0 : mcnt + 1;
        end
        rd_q.push_back(dout);
        exp_busy = (edge_n < load_end);
        started  = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (rd_q.size() > 0) chk("cpu_dout", cpu_dout, rd_q.pop_front());
            chk("busy", busy, exp_busy);
            if (sm_q.size() > 0 && sm_q[0].v == edge_n) begin
                chk("smp_valid", smp_valid, 1);
                chk("smp_o", smp_o, sm_q[0].smp);
                void'(sm_q.pop_front());
            end else begin
                chk("smp_valid_idle", smp_valid, 0);
            end
            if (wr_q.size() > 0 && wr_q[0].v == edge_n) begin
                chk("f_wr", f_wr, 1);
                chk("f_adr", f_adr, wr_q[0].adr);
                chk("f_din", f_din, wr_q[0].din);
                chk("f_wr_cnt", cnt, wr_q[0].cnt);
                void'(wr_q.pop_front());
            end else begin
                chk("f_wr_idle", f_wr, 0);
            end
        end
    end

    task automatic wr(input int a, input int d);
        cpu_we   = 1'b1;
        cpu_addr = 5'(a);
        cpu_din  = 13'(d);
        step();
        cpu_we   = 1'b0;
    endtask

    task automatic idle(input int n, input bit rnd_fo);
        repeat (n) begin
            cpu_addr = 5'($urandom_range(0, 31));
            if (rnd_fo) f_o = 15'($urandom);
            step();
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cnt", cnt, 0);
        chk("rst_f_wr", f_wr, 0);
        chk("rst_f_adr", f_adr, 0);
        chk("rst_f_din", f_din, 0);
        chk("rst_smp_o", smp_o, 0);
        chk("rst_smp_valid", smp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
    endtask

    initial begin
        bit reached;
        // Power-on reset
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk_reset_outputs();
        idle(40, 1);

        // Directed load of 0x100+k
        for (int k = 0; k < TAPS; k++) wr(k, 'h100 + k);
        wr(16, 1);
        idle(2 * PERIOD, 1);

        // Fixed filter output across a full period
        f_o = 15'h1234;
        idle(PERIOD + 8, 0);

        // Tap write while busy is dropped and flags err; err clear afterwards
        wr(16, 1);
        wr(3, 'h1FFF);
        cpu_addr = 5'd3;  step();
        cpu_addr = 5'd17; step();
        idle(2 * PERIOD, 1);
        cpu_addr = 5'd17; step();
        wr(16, 2);
        cpu_addr = 5'd17; step();

        // Second commit during WAIT_SYNC: one burst only, err set
        wr(16, 1);
        wr(16, 1);
        cpu_addr = 5'd17; step();
        idle(2 * PERIOD, 1);
        wr(16, 3);
        idle(PERIOD, 1);

        // Reset at cnt=20 while loading
        for (int k = 0; k < TAPS; k++) wr(k, $urandom);
        wr(16, 1);
        reached = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (edge_n >= load_start && mcnt == 20) begin
                reached = 1'b1;
                break;
            end
            cpu_addr = 5'($urandom_range(0, 31));
            step();
        end
        chk("reach_load_cnt20", reached, 1);
        rst = 1'b1;
        step();
        chk("midload_rst_f_wr", f_wr, 0);
        chk("midload_rst_busy", busy, 0);
        step();
        step();
        rst = 1'b0;
        chk_reset_outputs();
        cpu_addr = 5'd17; step();
        for (int k = 0; k < TAPS; k++) wr(k, $urandom);
        wr(16, 1);
        idle(2 * PERIOD, 1);

        // Randomized traffic
        repeat (4000) begin
            int r;
            f_o = 15'($urandom);
            r = $urandom_range(0, 99);
            if (r < 6)       wr($urandom_range(0, TAPS - 1), $urandom);
            else if (r < 8)  wr($urandom_range(17, 31), $urandom);
            else if (r < 10) wr(16, $urandom_range(0, 3));
            else             idle(1, 1);
        end

        idle(2 * PERIOD + TAPS + 4, 1);
        chk("wr_q_drained", wr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/psg_filter_coef_loader.md
Name: psg_filter_coef_loader

Overview:
- Front-end controller for the PSG FIR filter.
- Generates the filter's free-running sample-phase counter (cnt).
- Holds a CPU-writable shadow copy of the tap coefficients and, on commit, streams them into the filter's coefficient write port (wr/adr/din). Writes occur only in the idle part of the sample period, so the MAC loop never sees a half-updated coefficient.
- Captures the filter output once per sample period and presents it with a one-cycle valid strobe.

Parameters:
- TAPS, 16, number of filter taps; power of 2, at most 16 (filter address is 4 bits).
- CNT_MAX, 255, last cnt value before wrap; sample period = CNT_MAX+1 clocks; must be at least 2*TAPS+1.
- COEF_W, 13, coefficient word width: bit 12 = sign, bits 11:0 = magnitude.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset, synchronous, active-high.
- cpu_we, in, 1, CPU write strobe.
- cpu_addr, in, 5, 0..TAPS-1 = shadow coefficient; 16 = control; 17 = status.
- cpu_din, in, 13, CPU write data.
- cpu_dout, out, 13, registered read data for cpu_addr.
- cnt, out, 8, sample-phase counter to filter.
- f_wr, out, 1, filter coefficient write strobe.
- f_adr, out, 4, filter coefficient address.
- f_din, out, 13, filter coefficient data {sign, magnitude}.
- f_o, in, 15, filter output sample.
- smp_o, out, 15, captured output sample.
- smp_valid, out, 1, one-cycle strobe: smp_o updated.
- busy, out, 1, load in progress.

Behaviour:
- Reset values: cnt=0, f_wr=0, f_adr=0, f_din=0, smp_o=0, smp_valid=0, busy=0, cpu_dout=0, err=0, all shadow entries=0, FSM=IDLE.
- cnt increments every clock and wraps CNT_MAX -> 0.
- CPU write, addr < TAPS, busy=0: shadow[addr] <= cpu_din.
- CPU write, addr < TAPS, busy=1: write is dropped and sticky err <= 1.
- CPU write to addr 16:
  - bit0=1 requests commit; bit1=1 clears err.
  - Both bits may be set in the same write.
  - Commit while busy is ignored and sets err (set wins over a simultaneous clear).
- cpu_dout: one-cycle read latency.
  - addr < TAPS: shadow[addr].
  - addr 17: {11'b0, err, busy}.
  - addr 16, or addr 18-31: 0.
- Writes to addr 17-31 have no effect.
- FSM states:
  - IDLE: commit -> WAIT_SYNC; busy <= 1 on the same edge.
  - WAIT_SYNC: on the edge where cnt==TAPS-1 -> LOAD with idx=0.
  - LOAD: each cycle drives f_wr=1, f_adr=idx, f_din=shadow[idx], then idx++. Outputs are registered, so the writes land at cnt = TAPS..2*TAPS-1. After idx=TAPS-1 -> IDLE; f_wr=0 and busy=0 on the next edge.
- A commit issued in IDLE exactly when cnt==TAPS-1 waits a full sample period; there is no same-cycle shortcut.
- Load latency: from commit, up to CNT_MAX+1 clocks of sync wait plus TAPS clocks.
- f_wr is never 1 while cnt < TAPS.
- Output capture: on the edge where cnt==1, smp_o <= f_o and smp_valid <= 1; smp_valid is 0 on every other edge. The filter updates its output at cnt==0, so f_o is stable here.
- f_adr and f_din hold their last values when f_wr=0.
- Reset mid-LOAD: the FSM aborts to IDLE immediately; filter coefficients may be partially updated, and software re-commits.

Decomposition:
- Package psg_filter_pkg:
  - Constants ADDR_CTRL=16 and ADDR_STAT=17.
  - Control bit indices COMMIT=0, ERR_CLR=1.
  - FSM state enum {IDLE, WAIT_SYNC, LOAD}.
  - COEF_W-wide coefficient typedef.
- Sub-module psg_sample_seq: the cnt counter plus the cnt==TAPS-1 and cnt==1 decode strobes.
- Shadow RAM, CPU decode and FSM stay in the top module.

Test Plan:
- Reset: assert rst for 3 cycles mid-run -> all outputs 0, cnt restarts at 0, status read = 0.
- Load: write shadow[k] = 0x100+k for k=0..15, then commit -> 16 consecutive f_wr pulses at cnt=16..31, f_adr=0..15, f_din=0x100..0x10F; busy falls after the last pulse; no f_wr at cnt<16.
- Write while busy: write shadow[3] = 0x1FFF while busy -> shadow[3] unchanged; status = 0b11; then write ctrl=0b10 after busy=0 -> status 0b00.
- Double commit: commit, then commit again during WAIT_SYNC -> exactly one 16-write burst; err=1.
- Capture: drive f_o=0x1234 from cnt=0 -> smp_o=0x1234 and smp_valid=1 for exactly one cycle per 256-clock period.
- Reset mid-load: assert rst at cnt=20 during LOAD -> f_wr=0 next cycle, busy=0, FSM idle; a new commit completes normally.
